// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL sequencer: FSM states,
// PHASESEL encodings and default cycle counts.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      StRstPll,
      StWaitLock,
      StIdle,
      StSetup,
      StStep,
      StSettle,
      StDone
   } state_e;

   typedef logic [1:0] phase_sel_t;

   localparam phase_sel_t PhaseSelClkop  = 2'd0;
   localparam phase_sel_t PhaseSelClkos  = 2'd1;
   localparam phase_sel_t PhaseSelClkos2 = 2'd2;
   localparam phase_sel_t PhaseSelClkos3 = 2'd3;

   localparam int unsigned ReqCountW = 4;

   localparam int unsigned DefLockStableCycles  = 1024;
   localparam int unsigned DefLockTimeoutCycles = 65536;
   localparam int unsigned DefPllRstCycles      = 16;
   localparam int unsigned DefStepSetupCycles   = 4;
   localparam int unsigned DefStepWidthCycles   = 4;
   localparam int unsigned DefStepSettleCycles  = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Phase-shift request channel between a requester (master) and pll_phase_ctrl (slave).
interface pll_phase_ctrl_if;
   import pll_ctrl_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   phase_sel_t           req_sel;
   logic                 req_dir;
   logic [ReqCountW-1:0] req_count;
   logic                 busy;

   modport master (
      output req_valid, req_sel, req_dir, req_count,
      input  req_ready, busy
   );

   modport slave (
      input  req_valid, req_sel, req_dir, req_count,
      output req_ready, busy
   );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for a raw PLL LOCK plus a consecutive-cycle stability qualifier.
// The count only advances while enable is high and clears on any synchronized low.
module pll_lock_sync #(
   parameter int unsigned STABLE_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pll_locked,
   input  logic enable,
   output logic lock_s,
   output logic stable
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

   logic            meta_q;
   logic            sync_q;
   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable || !sync_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= pll_locked;
         sync_q <= meta_q;
         cnt_q  <= cnt_d;
      end
   end

   assign lock_s = sync_q;
   assign stable = (cnt_q == CntW'(STABLE_CYCLES));

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL sequencer: PLL reset, lock qualification and dynamic phase stepping.
// Define PLL_PHASE_CTRL_RELOCK_EN to re-pulse pll_rst on lock loss and lock timeout.
module pll_phase_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
   parameter int unsigned PLL_RST_CYCLES      = DefPllRstCycles,
   parameter int unsigned STEP_SETUP_CYCLES   = DefStepSetupCycles,
   parameter int unsigned STEP_WIDTH_CYCLES   = DefStepWidthCycles,
   parameter int unsigned STEP_SETTLE_CYCLES  = DefStepSettleCycles
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pll_locked,
   output logic             pll_rst,
   output phase_sel_t       pll_phasesel,
   output logic             pll_phasedir,
   output logic             pll_phasestep,
   output logic             sys_rst_n,
   output logic             locked_stable,
   output logic [7:0]       relock_count,
   pll_phase_ctrl_if.slave  req
);

   localparam int unsigned TmrMax = max_u(max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                                max_u(STEP_SETUP_CYCLES, STEP_WIDTH_CYCLES)),
                                          STEP_SETTLE_CYCLES);
   localparam int unsigned TmrW = $clog2(TmrMax + 1);

   state_e               state_q, state_d;
   logic [TmrW-1:0]      tmr_q, tmr_d;
   phase_sel_t           sel_q, sel_d;
   logic                 dir_q, dir_d;
   logic [ReqCountW-1:0] cnt_q, cnt_d;
   logic [7:0]           relock_q, relock_d;
   logic                 pll_rst_q, step_q, locked_q, busy_q, ready_q;
   logic                 lock_s, lock_ok, in_wait_lock, in_locked;

   assign in_wait_lock = (state_q == StWaitLock);
   assign in_locked    = state_q inside {StIdle, StSetup, StStep, StSettle, StDone};

   pll_lock_sync #(
      .STABLE_CYCLES (LOCK_STABLE_CYCLES)
   ) u_lock_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .pll_locked (pll_locked),
      .enable     (in_wait_lock),
      .lock_s     (lock_s),
      .stable     (lock_ok)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      relock_d = relock_q;
      // Lock loss beats every other transition, including a same-cycle request.
      if (in_locked && !lock_s) begin
`ifdef PLL_PHASE_CTRL_RELOCK_EN
         state_d = StRstPll;
`else
         state_d = StWaitLock;
`endif
         if (relock_q != 8'hff) relock_d = relock_q + 8'd1;
      end else begin
         unique case (state_q)
            StRstPll: begin
               if (tmr_q == TmrW'(PLL_RST_CYCLES - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
               if (lock_ok) begin
                  state_d = StIdle;
`ifdef PLL_PHASE_CTRL_RELOCK_EN
               end else if (tmr_q == TmrW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  state_d = StRstPll;
`endif
               end
            end
            StIdle: begin
               if (req.req_valid) begin
                  sel_d   = req.req_sel;
                  dir_d   = req.req_dir;
                  cnt_d   = req.req_count;
                  state_d = (req.req_count == '0) ? StDone : StSetup;
               end
            end
            StSetup: begin
               if (tmr_q == TmrW'(STEP_SETUP_CYCLES - 1)) state_d = StStep;
            end
            StStep: begin
               if (tmr_q == TmrW'(STEP_WIDTH_CYCLES - 1)) state_d = StSettle;
            end
            StSettle: begin
               if (tmr_q == TmrW'(STEP_SETTLE_CYCLES - 1)) begin
                  cnt_d   = cnt_q - ReqCountW'(1);
                  state_d = (cnt_q == ReqCountW'(1)) ? StDone : StSetup;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StRstPll;
         endcase
      end

      // One shared phase timer, restarted on every state change, saturating otherwise.
      if (state_d != state_q) begin
         tmr_d = '0;
      end else if (tmr_q != TmrW'(TmrMax)) begin
         tmr_d = tmr_q + TmrW'(1);
      end else begin
         tmr_d = tmr_q;
      end
   end

   // Outputs are registered from state_d so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StRstPll;
         tmr_q     <= '0;
         sel_q     <= PhaseSelClkop;
         dir_q     <= 1'b0;
         cnt_q     <= '0;
         relock_q  <= '0;
         pll_rst_q <= 1'b1;
         step_q    <= 1'b1;
         locked_q  <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         sel_q     <= sel_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         relock_q  <= relock_d;
         pll_rst_q <= (state_d == StRstPll);
         step_q    <= (state_d != StStep);
         locked_q  <= state_d inside {StIdle, StSetup, StStep, StSettle, StDone};
         busy_q    <= state_d inside {StSetup, StStep, StSettle, StDone};
         ready_q   <= (state_d == StIdle);
      end
   end

   assign pll_rst       = pll_rst_q;
   assign pll_phasesel  = sel_q;
   assign pll_phasedir  = dir_q;
   assign pll_phasestep = step_q;
   assign sys_rst_n     = locked_q;
   assign locked_stable = locked_q;
   assign relock_count  = relock_q;
   assign req.req_ready = ready_q;
   assign req.busy      = busy_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with short lock/timeout counts (64 / 256).
module tb_pll_phase_ctrl;
   import pll_ctrl_pkg::*;

`ifdef PLL_PHASE_CTRL_RELOCK_EN
   localparam int RelockEn = 1;
`else
   localparam int RelockEn = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   phase_sel_t pll_phasesel;
   logic       pll_phasedir;
   logic       pll_phasestep;
   logic       sys_rst_n;
   logic       locked_stable;
   logic [7:0] relock_count;

   pll_phase_ctrl_if req_if ();

   pll_phase_ctrl #(
      .LOCK_STABLE_CYCLES  (64),
      .LOCK_TIMEOUT_CYCLES (256),
      .PLL_RST_CYCLES      (16),
      .STEP_SETUP_CYCLES   (4),
      .STEP_WIDTH_CYCLES   (4),
      .STEP_SETTLE_CYCLES  (8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pll_locked    (pll_locked),
      .pll_rst       (pll_rst),
      .pll_phasesel  (pll_phasesel),
      .pll_phasedir  (pll_phasedir),
      .pll_phasestep (pll_phasestep),
      .sys_rst_n     (sys_rst_n),
      .locked_stable (locked_stable),
      .relock_count  (relock_count),
      .req           (req_if.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n, n_busy, n_low, n_badsel, n_rises, f0, f1, f2, r0, r1;
   int falls[$];
   logic prev;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int cycles = 1);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_sys_rst(input int limit, output int cycles);
      cycles = 0;
      while (!sys_rst_n && cycles < limit) begin
         tick(1);
         cycles++;
      end
   endtask

   task automatic send_req(input int sel, input int dir, input int cnt);
      req_if.req_valid = 1'b1;
      req_if.req_sel   = phase_sel_t'(sel);
      req_if.req_dir   = dir[0];
      req_if.req_count = ReqCountW'(cnt);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got running, want done");
      $fatal(1);
   end

   initial begin
      req_if.req_valid = 1'b0;
      req_if.req_sel   = '0;
      req_if.req_dir   = 1'b0;
      req_if.req_count = '0;
      tick(3);

      check_eq("rst_pll_rst", pll_rst, 1);
      check_eq("rst_phasestep", pll_phasestep, 1);
      check_eq("rst_phasesel", pll_phasesel, 0);
      check_eq("rst_phasedir", pll_phasedir, 0);
      check_eq("rst_sys_rst_n", sys_rst_n, 0);
      check_eq("rst_locked_stable", locked_stable, 0);
      check_eq("rst_req_ready", req_if.req_ready, 0);
      check_eq("rst_busy", req_if.busy, 0);
      check_eq("rst_relock_count", relock_count, 0);

      // PLL reset pulse after release.
      reset_n = 1'b1;
      n = 0;
      while (pll_rst && n < 100) begin
         tick(1);
         n++;
      end
      check_eq("pll_rst_width", n, 16);

      // Lock at cycle 20: 2 sync + 64 stable + 1 registered edge.
      tick(4);
      pll_locked = 1'b1;
      wait_sys_rst(200, n);
      check_eq("lock_qual_latency", n, 67);
      check_eq("lock_qual_stable", locked_stable, 1);
      check_eq("lock_qual_ready", req_if.req_ready, 1);

      // Glitch at stable count 40 restarts qualification from the re-rise.
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(20);
      pll_locked = 1'b1;
      tick(42);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      wait_sys_rst(200, n);
      check_eq("glitch_requal_latency", n, 67);

      // Three steps, sel=2 dir=1: 4 setup + 4 low + 8 settle each, then DONE.
      send_req(2, 1, 3);
      tick(1);
      req_if.req_valid = 1'b0;
      check_eq("accept_busy", req_if.busy, 1);
      check_eq("accept_ready", req_if.req_ready, 0);
      n_busy   = 0;
      n_low    = 0;
      n_badsel = 0;
      prev     = 1'b1;
      falls.delete();
      for (int i = 0; i < 200; i++) begin
         if (!req_if.busy) break;
         n_busy++;
         if (!pll_phasestep) n_low++;
         if (prev && !pll_phasestep) falls.push_back(i);
         if (pll_phasesel != 2'd2 || pll_phasedir != 1'b1) n_badsel++;
         prev = pll_phasestep;
         tick(1);
      end
      f0 = (falls.size() > 0) ? falls[0] : -1;
      f1 = (falls.size() > 1) ? falls[1] : -1;
      f2 = (falls.size() > 2) ? falls[2] : -1;
      check_eq("step3_busy_cycles", n_busy, 49);
      check_eq("step3_low_cycles", n_low, 12);
      check_eq("step3_fall_count", falls.size(), 3);
      check_eq("step3_first_fall", f0, 4);
      check_eq("step3_spacing_a", f1 - f0, 16);
      check_eq("step3_spacing_b", f2 - f1, 16);
      check_eq("step3_sel_dir_stable", n_badsel, 0);
      check_eq("step3_ready_after", req_if.req_ready, 1);
      check_eq("step3_sel_held", pll_phasesel, 2);

      // Zero-count request: only the DONE cycle.
      send_req(1, 0, 0);
      tick(1);
      req_if.req_valid = 1'b0;
      check_eq("zero_busy", req_if.busy, 1);
      check_eq("zero_ready_low", req_if.req_ready, 0);
      check_eq("zero_step_idle", pll_phasestep, 1);
      tick(1);
      check_eq("zero_busy_done", req_if.busy, 0);
      check_eq("zero_ready_back", req_if.req_ready, 1);
      check_eq("zero_sel_latched", pll_phasesel, 1);
      check_eq("zero_dir_latched", pll_phasedir, 0);

      // Reset asserted while PHASESTEP is low.
      send_req(3, 1, 2);
      tick(1);
      req_if.req_valid = 1'b0;
      tick(5);
      check_eq("midrst_step_low", pll_phasestep, 0);
      reset_n = 1'b0;
      tick(1);
      check_eq("midrst_step_high", pll_phasestep, 1);
      check_eq("midrst_busy", req_if.busy, 0);
      check_eq("midrst_pll_rst", pll_rst, 1);
      check_eq("midrst_sel", pll_phasesel, 0);
      check_eq("midrst_sys_rst_n", sys_rst_n, 0);
      reset_n = 1'b1;
      wait_sys_rst(300, n);
      check_eq("midrst_requal", n, 81);

      // Lock loss while in STEP.
      send_req(2, 1, 1);
      tick(1);
      req_if.req_valid = 1'b0;
      tick(2);
      pll_locked = 1'b0;
      tick(2);
      check_eq("loss_step_low", pll_phasestep, 0);
      check_eq("loss_sys_before", sys_rst_n, 1);
      tick(1);
      check_eq("loss_step_high", pll_phasestep, 1);
      check_eq("loss_sys_rst_n", sys_rst_n, 0);
      check_eq("loss_locked_stable", locked_stable, 0);
      check_eq("loss_busy", req_if.busy, 0);
      check_eq("loss_relock_count", relock_count, 1);
      n = 0;
      while (pll_rst && n < 100) begin
         n++;
         tick(1);
      end
      check_eq("loss_pll_rst_width", n, 16 * RelockEn);

      // Lock held low: timeout behaviour.
      n_rises = 0;
      r0 = 0;
      r1 = 0;
      prev = pll_rst;
      for (int i = 0; i < 600; i++) begin
         tick(1);
         if (!prev && pll_rst) begin
            if (n_rises == 0) r0 = i;
            if (n_rises == 1) r1 = i;
            n_rises++;
         end
         prev = pll_rst;
      end
      check_eq("timeout_rises", n_rises, 2 * RelockEn);
      check_eq("timeout_period", r1 - r0, 272 * RelockEn);
      check_eq("timeout_sys_rst_n", sys_rst_n, 0);
      check_eq("timeout_relock_count", relock_count, 1);

      pll_locked = 1'b1;
      wait_sys_rst(200, n);
      check_eq("relock_latency", n, 67);
      check_eq("relock_ready", req_if.req_ready, 1);

      // Lock loss and request seen on the same edge: loss wins.
      pll_locked = 1'b0;
      tick(2);
      send_req(3, 0, 1);
      tick(1);
      req_if.req_valid = 1'b0;
      check_eq("race_busy", req_if.busy, 0);
      check_eq("race_ready", req_if.req_ready, 0);
      check_eq("race_sel_unchanged", pll_phasesel, 2);
      check_eq("race_relock_count", relock_count, 2);
      check_eq("race_sys_rst_n", sys_rst_n, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Sequencer for the ECP5 EHXPLLL clock generator. It handles three jobs:
- owns the PLL reset;
- qualifies the raw LOCK output and releases a synchronous downstream reset only after lock has been stable;
- executes dynamic phase-shift requests by driving PHASESEL/PHASEDIR/PHASESTEP with the required setup, pulse and settle spacing.

It runs on the free-running PLL reference clock, not on any PLL output, and sits beside the PLL wrapper at the top level.

## Interface
Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before declaring stable.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a relock attempt.
- PLL_RST_CYCLES, 16: width of the pll_rst pulse.
- STEP_SETUP_CYCLES, 4: cycles sel/dir are held before PHASESTEP falls.
- STEP_WIDTH_CYCLES, 4: cycles PHASESTEP is held low.
- STEP_SETTLE_CYCLES, 8: cycles after PHASESTEP rises before the next step.

Ports:
- clk  in  1  reference clock, free-running.
- reset_n  in  1  synchronous active-low reset.
- pll_locked  in  1  raw PLL LOCK, asynchronous to clk.
- pll_rst  out  1  PLL RST, active-high.
- pll_phasesel  out  2  PHASESEL[1:0] (0..3 = CLKOP..CLKOS3).
- pll_phasedir  out  1  PHASEDIR.
- pll_phasestep  out  1  PHASESTEP, idle high, active-low pulse.
- sys_rst_n  out  1  downstream reset, active-low, registered.
- locked_stable  out  1  lock qualified.
- req_valid  in  1  phase-shift request.
- req_ready  out  1  request accepted when valid&ready.
- req_sel  in  2  target output.
- req_dir  in  1  direction, passed to PHASEDIR.
- req_count  in  4  number of steps; 0 is legal.
- busy  out  1  phase-shift sequence in progress.
- relock_count  out  8  lock-loss events, saturating at 255.

## Operation
- pll_locked passes through a 2-flop synchronizer; lock_s is the synchronizer output.
- States:
  - RST_PLL: pll_rst=1 for PLL_RST_CYCLES, then WAIT_LOCK.
  - WAIT_LOCK: counter counts consecutive lock_s=1 cycles and clears on lock_s=0. Reaching LOCK_STABLE_CYCLES goes to IDLE. Timeout counter reaching LOCK_TIMEOUT_CYCLES goes to RST_PLL.
  - IDLE: req_ready=1. On accept, latch sel/dir/count. count=0 goes to DONE, otherwise SETUP.
  - SETUP: drive latched sel/dir for STEP_SETUP_CYCLES, then STEP.
  - STEP: pll_phasestep=0 for STEP_WIDTH_CYCLES, then SETTLE.
  - SETTLE: pll_phasestep=1 for STEP_SETTLE_CYCLES. Decrement the remaining count; nonzero goes to SETUP, zero goes to DONE.
  - DONE: one cycle, then IDLE.
- Lock loss: lock_s=0 in IDLE/SETUP/STEP/SETTLE/DONE aborts immediately.
  - pll_phasestep returns to 1 and sys_rst_n/locked_stable drop in the same cycle the state is left.
  - relock_count increments.
  - Next state is RST_PLL with RELOCK_EN compiled in, WAIT_LOCK without.
- sys_rst_n = locked_stable, registered. It is 1 only in IDLE/SETUP/STEP/SETTLE/DONE.
- busy=1 in SETUP/STEP/SETTLE/DONE.
- pll_phasesel/pll_phasedir hold their last latched value outside a sequence.
- req_ready is 0 in every state except IDLE. The requester must hold fields stable while req_valid=1 and !req_ready.
- Counters are sized with $clog2(param+1) and saturate, never wrap.

## Timing
- Reset values: state RST_PLL, pll_rst=1, pll_phasestep=1, pll_phasesel=0, pll_phasedir=0, sys_rst_n=0, locked_stable=0, req_ready=0, busy=0, relock_count=0.
- Lock qualification latency: 2 synchronizer cycles + LOCK_STABLE_CYCLES. The cycle after the count is reached, locked_stable=1, sys_rst_n=1, req_ready=1.
- Per step: STEP_SETUP_CYCLES+STEP_WIDTH_CYCLES+STEP_SETTLE_CYCLES. Total from accept to IDLE: count×that + 1 (DONE).
- Accept edge: the cycle after the accept, busy=1 and req_ready=0.
- Simultaneous lock loss and req_valid in IDLE: lock loss wins and the request is not accepted.
- reset_n low mid-sequence: synchronous return to reset values on the next edge. pll_phasestep=1 is guaranteed.

## Configuration
- PLL_PHASE_CTRL_RELOCK_EN defined: lock loss and WAIT_LOCK timeout both go to RST_PLL and pulse pll_rst.
- PLL_PHASE_CTRL_RELOCK_EN undefined:
  - pll_rst is 1 only after reset, then constant 0.
  - Lock loss returns to WAIT_LOCK.
  - Timeout does not exit WAIT_LOCK; the timeout counter saturates.
  - relock_count still counts lock-loss events.

## Structure
- Shared package pll_ctrl_pkg holds:
  - state enum (RST_PLL, WAIT_LOCK, IDLE, SETUP, STEP, SETTLE, DONE);
  - PHASESEL encoding constants;
  - default cycle-count constants.
- One sub-module, pll_lock_sync: the 2-flop synchronizer plus stable-count qualifier, reusable for other PLLs.
- The FSM, step counters and request latch stay in pll_phase_ctrl.

## Test plan
- Lock qualification: reset, then pll_locked rises at cycle 20 and stays high, LOCK_STABLE_CYCLES=64 → sys_rst_n rises exactly 2+64 cycles after lock_s sees 1 (±1 for the registered edge).
- Glitched lock: pll_locked low for 1 cycle during WAIT_LOCK at count 40 → stable counter restarts and sys_rst_n is delayed by a full 64 cycles.
- Three-step shift: req sel=2, dir=1, count=3, defaults → three phasestep low pulses of 4 cycles, 12 cycles apart; phasesel=2 and phasedir=1 are stable 4 cycles before each fall; busy is high for 3×16+1 cycles.
- Zero-count request: count=0 → no phasestep pulse, busy high for 1 cycle, req_ready back the following cycle.
- Lock loss mid-STEP with RELOCK_EN: → phasestep=1 the next cycle, pll_rst high for 16 cycles, relock_count=1, sys_rst_n=0 until re-qualified.
- Timeout: pll_locked held low, LOCK_TIMEOUT_CYCLES=256 → pll_rst pulses every 16+256 cycles with RELOCK_EN defined, never without it.
